// File: rtl/regfile_sequencer_if.sv
// Register-access command channel plus register file control and shared data
// bus, bundled so the control unit and the sequencer connect through one port.
interface regfile_sequencer_if #(
    parameter int DATA_WIDTH     = 16,
    parameter int REG_ADDR_WIDTH = 4
);
    // Command handshake from the control unit
    logic                      req_valid;
    logic                      req_ready;
    logic [1:0]                req_op;
    logic [REG_ADDR_WIDTH-1:0] req_rx;
    logic [REG_ADDR_WIDTH-1:0] req_ry;
    logic [REG_ADDR_WIDTH-1:0] req_rz;
    logic [DATA_WIDTH-1:0]     wr_data;

    // Register file control and shared bus
    logic [REG_ADDR_WIDTH-1:0] register_select;
    logic                      reg_file_in;
    logic                      reg_file_out;
    logic [DATA_WIDTH-1:0]     bus_in;
    logic [DATA_WIDTH-1:0]     bus_out;
    logic                      bus_oe;

    // Results towards the ALU
    logic [DATA_WIDTH-1:0]     operand_a;
    logic [DATA_WIDTH-1:0]     operand_b;
    logic                      done;

    // Control unit / top-level side: issues commands, resolves the bus
    modport master (
        output req_valid, req_op, req_rx, req_ry, req_rz, wr_data, bus_in,
        input  req_ready, register_select, reg_file_in, reg_file_out,
               bus_out, bus_oe, operand_a, operand_b, done
    );

    // Sequencer side
    modport slave (
        input  req_valid, req_op, req_rx, req_ry, req_rz, wr_data, bus_in,
        output req_ready, register_select, reg_file_in, reg_file_out,
               bus_out, bus_oe, operand_a, operand_b, done
    );
endinterface

// File: rtl/regfile_sequencer.sv
// Micro-sequencer for the Hmmm register file: accepts one register-access
// command, runs it as single-cycle bus transactions, latches read operands
// and pulses done. The register file never drives and samples the bus in the
// same cycle, and writes to r0 can be suppressed.
module regfile_sequencer #(
    parameter int DATA_WIDTH       = 16,
    parameter int REG_ADDR_WIDTH   = 4,
    parameter int R0_WRITE_PROTECT = 1
) (
    input  logic               clk,
    input  logic               rst,
    regfile_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_A,
        S_RD_B,
        S_WR,
        S_DONE
    } state_e;

    typedef enum logic [1:0] {
        OP_NOP     = 2'b00,
        OP_READ_A  = 2'b01,
        OP_READ_AB = 2'b10,
        OP_WRITE   = 2'b11
    } op_e;

    state_e                    state_q, state_d;
    op_e                       op_q;
    logic [REG_ADDR_WIDTH-1:0] rx_q, ry_q, rz_q;
    logic [DATA_WIDTH-1:0]     wr_data_q;
    logic [DATA_WIDTH-1:0]     operand_a_q, operand_a_d;
    logic [DATA_WIDTH-1:0]     operand_b_q, operand_b_d;
    logic                      accept;
    logic                      wr_blocked;

    // A write to r0 still spends its cycle but never pulses the register file
    assign wr_blocked = (R0_WRITE_PROTECT != 0) && (rx_q == '0);

    assign bus.operand_a = operand_a_q;
    assign bus.operand_b = operand_b_q;

    // State register and command latch; everything clears asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            op_q      <= OP_NOP;
            rx_q      <= '0;
            ry_q      <= '0;
            rz_q      <= '0;
            wr_data_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values; blocking here would chain state within one edge.
            state_q <= state_d;
            if (accept) begin
                op_q      <= op_e'(bus.req_op);
                rx_q      <= bus.req_rx;
                ry_q      <= bus.req_ry;
                rz_q      <= bus.req_rz;
                wr_data_q <= bus.wr_data;
            end
        end
    end

    // Operand latches: a reset mid-command discards any partially read operand
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            operand_a_q <= '0;
            operand_b_q <= '0;
        end else begin
            operand_a_q <= operand_a_d;
            operand_b_q <= operand_b_d;
        end
    end

    // Next-state, operand capture and Moore outputs for the command sequence
    always_comb begin
        // NOTE: every signal gets a default before the case so no path through
        // the block leaves one unassigned, which would infer a latch.
        state_d             = state_q;
        accept              = 1'b0;
        operand_a_d         = operand_a_q;
        operand_b_d         = operand_b_q;
        bus.req_ready       = 1'b0;
        bus.register_select = '0;
        bus.reg_file_in     = 1'b0;
        bus.reg_file_out    = 1'b0;
        bus.bus_out         = '0;
        bus.bus_oe          = 1'b0;
        bus.done            = 1'b0;

        case (state_q)
            S_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    accept = 1'b1;
                    case (op_e'(bus.req_op))
                        OP_NOP:     state_d = S_DONE;
                        OP_READ_A:  state_d = S_RD_A;
                        OP_READ_AB: state_d = S_RD_A;
                        OP_WRITE:   state_d = S_WR;
                        default:    state_d = S_DONE;
                    endcase
                end
            end

            S_RD_A: begin
                bus.register_select = ry_q;
                bus.reg_file_out    = 1'b1;
                operand_a_d         = bus.bus_in;
                state_d             = (op_q == OP_READ_AB) ? S_RD_B : S_DONE;
            end

            S_RD_B: begin
                bus.register_select = rz_q;
                bus.reg_file_out    = 1'b1;
                operand_b_d         = bus.bus_in;
                state_d             = S_DONE;
            end

            S_WR: begin
                bus.register_select = rx_q;
                bus.bus_out         = wr_data_q;
                bus.bus_oe          = !wr_blocked;
                bus.reg_file_in     = !wr_blocked;
                state_d             = S_DONE;
            end

            S_DONE: begin
                bus.done = 1'b1;
                state_d  = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: doc/regfile_sequencer.md
Name: regfile_sequencer

Overview:
- Micro-sequencer that owns the control side of the Hmmm register file (register_select, reg_file_in, reg_file_out) and its 16-bit shared data bus.
- Takes one register-access command at a time from the control unit: read one operand, read two operands, or write back a result.
- Runs the command as a fixed sequence of single-cycle bus transactions, latches the read operands for the ALU, and pulses done.
- Guarantees the register file never drives and samples the bus in the same cycle, and enforces the Hmmm rule that r0 is read-only zero.

Parameters:
DATA_WIDTH, 16, bus and operand width
REG_ADDR_WIDTH, 4, register index width (16 registers)
R0_WRITE_PROTECT, 1, when 1 a WRITE to r0 issues no reg_file_in pulse

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-low
req_valid  input  1  command present
req_ready  output  1  sequencer can accept a command; high only in IDLE
req_op  input  2  00 NOP, 01 READ_A, 10 READ_AB, 11 WRITE
req_rx  input  REG_ADDR_WIDTH  destination register (WRITE)
req_ry  input  REG_ADDR_WIDTH  first source register (READ_A, READ_AB)
req_rz  input  REG_ADDR_WIDTH  second source register (READ_AB)
wr_data  input  DATA_WIDTH  write-back value, sampled at acceptance
register_select  output  REG_ADDR_WIDTH  register file index
reg_file_in  output  1  register file captures bus at this clock edge
reg_file_out  output  1  register file drives bus this cycle
bus_in  input  DATA_WIDTH  resolved shared bus value
bus_out  output  DATA_WIDTH  value this block drives onto the bus
bus_oe  output  1  bus_out drive enable (tri-state control, top level)
operand_a  output  DATA_WIDTH  latched first operand
operand_b  output  DATA_WIDTH  latched second operand
done  output  1  one-cycle pulse when the command completes

Behaviour:
- States: IDLE, RD_A, RD_B, WR, DONE. The state register and the latched command fields (op, rx, ry, rz, wr_data) reset asynchronously.
- Reset (rst=0): state goes to IDLE and operand_a/operand_b go to 0 immediately, without waiting for a clock.
- Outputs in reset and in IDLE: register_select=0, reg_file_in=0, reg_file_out=0, bus_oe=0, bus_out=0, done=0, req_ready=1.
- Acceptance: at the clock edge where req_valid && req_ready, all command fields are latched. Inputs are ignored outside IDLE.
- Transitions taken on the edge that accepts a command, by req_op:
  - NOP: to DONE.
  - READ_A: to RD_A.
  - READ_AB: to RD_A.
  - WRITE: to WR.
- RD_A:
  - Drives register_select=ry and reg_file_out=1.
  - At the cycle's closing edge, operand_a <= bus_in.
  - Next state is RD_B for READ_AB, otherwise DONE.
- RD_B:
  - Drives register_select=rz and reg_file_out=1.
  - At the closing edge, operand_b <= bus_in.
  - Next state is DONE.
- WR:
  - Drives register_select=rx, bus_oe=1, bus_out=latched wr_data, reg_file_in=1.
  - If rx==0 and R0_WRITE_PROTECT=1: reg_file_in=0 and bus_oe=0, but the cycle is still spent so latency does not depend on data.
  - Next state is DONE.
- DONE: done=1 and req_ready=0 for one cycle, then IDLE.
- Latency from the accept edge to the done-high cycle:
  - NOP: 1 cycle.
  - READ_A: 2 cycles.
  - WRITE: 2 cycles.
  - READ_AB: 3 cycles.
  - The minimum spacing between accepts is latency+1.
- Operand hold:
  - operand_a/operand_b are updated only in RD_A/RD_B and otherwise hold their value across commands.
  - READ_A leaves operand_b unchanged.
- Invariants (assertable):
  - reg_file_in and reg_file_out are never both 1.
  - bus_oe is never 1 while reg_file_out=1.
  - done is high for exactly one cycle per accepted command.
- Reads from r0 are performed normally; the register file supplies 0.
- Reset mid-command: the sequence aborts and outputs fall to their reset values asynchronously. No done is issued and no partial operand is retained (both operands return to 0).

Test Plan:
- Reset, then WRITE rx=1, wr_data=0x1234 -> WR cycle shows select=1, bus_oe=1, reg_file_in=1; done 2 cycles after accept; the register file model then holds r1=0x1234.
- Preload r14=0x00AA, r15=0x5555, then READ_AB ry=14, rz=15 -> RD_A select=14, RD_B select=15; operand_a=0x00AA, operand_b=0x5555; done 3 cycles after accept.
- READ_A ry=1 after the previous test -> operand_a=0x1234, operand_b stays 0x5555, done 2 cycles after accept.
- WRITE rx=0, wr_data=0xFFFF -> reg_file_in and bus_oe stay 0 for the whole command, done still at +2; a later READ_A ry=0 returns operand_a=0.
- Hold req_valid=1 with back-to-back NOP then READ_A -> req_ready low during DONE; second accept on the IDLE cycle; no second accept while busy; reg_file_in & reg_file_out never both high.
- Assert rst=0 mid READ_AB (in RD_B) between clock edges -> all outputs 0 and operands 0 immediately; no done; after release req_ready=1 and a new READ_A completes normally.
